// File: rtl/inst_fetch_controller.sv
// Instruction fetch sequencer: host pass-through to BlockRam while idle, PC-driven fetch with valid/ready while running.
// Optional FETCH_STATS_EN adds a saturating accepted-transfer counter (fetch_count).
module inst_fetch_controller #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int WORD_WIDTH    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_pc,
  input  logic                     halt,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     running,
  input  logic [ADDRESS_WIDTH-1:0] ext_address,
  input  logic                     ext_write,
  input  logic [WORD_WIDTH-1:0]    ext_in_data,
  output logic                     ext_busy,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_write,
  output logic [WORD_WIDTH-1:0]    ram_write_data,
  input  logic [WORD_WIDTH-1:0]    ram_read_data,
  output logic                     insn_valid,
  output logic [WORD_WIDTH-1:0]    insn,
  output logic [ADDRESS_WIDTH-1:0] insn_pc,
  input  logic                     insn_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]              fetch_count
`endif
);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, HOLD} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic                     transfer;

  assign transfer       = insn_valid && insn_ready;
  assign ext_busy       = running;
  assign ram_write_data = ext_in_data;

  // Host owns the RAM port only while idle; reset forces IDLE, so the mux reverts asynchronously.
  always_comb begin
    ram_address = pc;
    ram_write   = 1'b0;
    if (state == IDLE) begin
      ram_address = ext_address;
      ram_write   = ext_write;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= '0;
      insn_valid <= 1'b0;
      insn       <= '0;
      insn_pc    <= '0;
      running    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc      <= start_pc;
            state   <= READ;
            running <= 1'b1;
          end
        end
        default: begin
          // halt beats redirect beats normal progression
          if (halt) begin
            insn_valid <= 1'b0;
            running    <= 1'b0;
            state      <= IDLE;
          end else if (redirect) begin
            pc         <= redirect_pc;
            insn_valid <= 1'b0;
            state      <= READ;
          end else begin
            case (state)
              READ: state <= CAPTURE;
              CAPTURE: begin
                insn       <= ram_read_data;
                insn_pc    <= pc;
                insn_valid <= 1'b1;
                pc         <= pc + ADDRESS_WIDTH'(1);
                state      <= HOLD;
              end
              HOLD: begin
                if (insn_ready) begin
                  insn_valid <= 1'b0;
                  state      <= READ;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (state == IDLE && start) begin
      fetch_count <= '0;
    end else if (transfer && fetch_count != '1) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule
